// File: rtl/alu_div_arb_pkg.sv
// Shared opcodes, state encoding and helpers for the divider arbiter.
// The opcode values match cv32e40p_pkg::alu_opcode_e for the four divide operations.
package alu_div_arb_pkg;

  localparam logic [6:0] ALU_DIVU = 7'b0110000;
  localparam logic [6:0] ALU_DIV  = 7'b0110001;
  localparam logic [6:0] ALU_REMU = 7'b0110010;
  localparam logic [6:0] ALU_REM  = 7'b0110011;

  // Worst-case latency of the iterative divider, in cycles.
  localparam int DIV_MAX_CYC = 35;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  function automatic logic is_div_op(input logic [6:0] op);
    return op inside {ALU_DIVU, ALU_DIV, ALU_REMU, ALU_REM};
  endfunction

  // RISC-V divide-by-zero results: all ones for quotients, dividend for remainders.
  function automatic logic [31:0] zero_div_result(input logic [6:0] op, input logic [31:0] dividend);
    return (op == ALU_DIVU || op == ALU_DIV) ? 32'hFFFF_FFFF : dividend;
  endfunction

endpackage

// File: rtl/alu_div_rr_arb.sv
// Round-robin picker: first asserted request after the last granted index wins.
module alu_div_rr_arb #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   last_i,
  output logic [NUM_REQ-1:0] gnt_o
);

  logic             found;
  logic [PTR_W-1:0] idx;

  // NOTE: every variable written here gets a default first, so no latch can be inferred.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = PTR_W'((int'(last_i) + off) % NUM_REQ);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_div_arbiter.sv
// Shares one iterative divider between NUM_REQ requesters with a watchdog abort.
// Define ALU_DIV_ARB_FAST_ZERO_EN to answer divide-by-zero without using the divider.
module alu_div_arbiter
  import alu_div_arb_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT_CYC = 40
) (
  input  logic                  core_clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid_i,
  output logic [NUM_REQ-1:0]    req_ready_o,
  input  logic [NUM_REQ*7-1:0]  req_op_i,
  input  logic [NUM_REQ*32-1:0] req_a_i,
  input  logic [NUM_REQ*32-1:0] req_b_i,
  output logic [NUM_REQ-1:0]    rsp_valid_o,
  input  logic [NUM_REQ-1:0]    rsp_ready_i,
  output logic [31:0]           rsp_result_o,
  output logic                  rsp_err_o,
  output logic                  div_enable_o,
  output logic [6:0]            div_operator_o,
  output logic [31:0]           div_operand_a_o,
  output logic [31:0]           div_operand_b_o,
  output logic                  div_ex_ready_o,
  input  logic                  div_ready_i,
  input  logic [31:0]           div_result_i
);

  localparam int PTR_W = $clog2(NUM_REQ);
  // The watchdog never fires before the divider's own worst case could complete.
  localparam int         WD_LIMIT = (TIMEOUT_CYC > DIV_MAX_CYC) ? TIMEOUT_CYC : DIV_MAX_CYC + 1;
  localparam logic [5:0] WD_LAST  = 6'(WD_LIMIT - 1);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_BUSY = BUSY;
  localparam logic [1:0] ST_RESP = RESP;

  logic [1:0]       state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] owner_q, owner_d;
  logic [6:0]       op_q, op_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [31:0]      result_q, result_d;
  logic             err_q, err_d;
  logic [5:0]       wd_cnt_q, wd_cnt_d;

  logic [NUM_REQ-1:0] gnt;
  logic [PTR_W-1:0]   gnt_idx;
  logic [6:0]         sel_op;
  logic [31:0]        sel_a, sel_b;

  alu_div_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arb (
    .req_i  (req_valid_i),
    .last_i (ptr_q),
    .gnt_o  (gnt)
  );

  always_comb begin
    gnt_idx = '0;
    sel_op  = '0;
    sel_a   = '0;
    sel_b   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        gnt_idx = PTR_W'(i);
        sel_op  = req_op_i[i*7 +: 7];
        sel_a   = req_a_i[i*32 +: 32];
        sel_b   = req_b_i[i*32 +: 32];
      end
    end
  end

  // Nothing is accepted while reset is asserted, so no request is silently lost.
  assign req_ready_o = (state_q == ST_IDLE && !rst) ? gnt : '0;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    err_d    = err_q;
    wd_cnt_d = wd_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (|req_ready_o) begin
          ptr_d    = gnt_idx;
          owner_d  = gnt_idx;
          op_d     = sel_op;
          a_d      = sel_a;
          b_d      = sel_b;
          wd_cnt_d = '0;
          if (!is_div_op(sel_op)) begin
            result_d = '0;
            err_d    = 1'b1;
            state_d  = ST_RESP;
          end
`ifdef ALU_DIV_ARB_FAST_ZERO_EN
          else if (sel_b == '0) begin
            result_d = zero_div_result(sel_op, sel_a);
            err_d    = 1'b0;
            state_d  = ST_RESP;
          end
`endif
          else begin
            err_d   = 1'b0;
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        if (div_ready_i) begin
          result_d = div_result_i;
          err_d    = 1'b0;
          state_d  = ST_RESP;
        end else if (wd_cnt_q == WD_LAST) begin
          // Leaving BUSY drops div_enable_o, which aborts the divider.
          result_d = '0;
          err_d    = 1'b1;
          state_d  = ST_RESP;
        end else begin
          wd_cnt_d = wd_cnt_q + 6'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i[owner_q]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge core_clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ptr_q    <= PTR_W'(NUM_REQ - 1);
      owner_q  <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      wd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      err_q    <= err_d;
      wd_cnt_q <= wd_cnt_d;
    end
  end

  assign div_enable_o    = (state_q == ST_BUSY);
  assign div_ex_ready_o  = div_enable_o;
  assign div_operator_o  = div_enable_o ? op_q : '0;
  assign div_operand_a_o = div_enable_o ? a_q : '0;
  assign div_operand_b_o = div_enable_o ? b_q : '0;

  assign rsp_valid_o  = (state_q == ST_RESP) ? (NUM_REQ'(1) << owner_q) : '0;
  assign rsp_result_o = (state_q == ST_RESP) ? result_q : '0;
  assign rsp_err_o    = (state_q == ST_RESP) && err_q;

endmodule

// File: tb/tb_alu_div_arbiter.sv
// Self-checking bench for alu_div_arbiter: a divider stand-in, a transaction-level model and directed vectors.
// Build with ALU_DIV_ARB_FAST_ZERO_EN defined to check the divide-by-zero bypass.
module tb_alu_div_arbiter;

  localparam int NUM_REQ     = 2;
  localparam int TIMEOUT_CYC = 40;

  localparam logic [6:0] OP_DIVU = 7'b0110000;
  localparam logic [6:0] OP_DIV  = 7'b0110001;
  localparam logic [6:0] OP_REMU = 7'b0110010;
  localparam logic [6:0] OP_REM  = 7'b0110011;
  localparam logic [6:0] OP_ADD  = 7'b0011000;

  logic                  core_clk, rst;
  logic [NUM_REQ-1:0]    req_valid_i, req_ready_o, rsp_valid_o, rsp_ready_i;
  logic [NUM_REQ*7-1:0]  req_op_i;
  logic [NUM_REQ*32-1:0] req_a_i, req_b_i;
  logic [31:0]           rsp_result_o, div_operand_a_o, div_operand_b_o, div_result_i;
  logic                  rsp_err_o, div_enable_o, div_ex_ready_o, div_ready_i;
  logic [6:0]            div_operator_o;

  alu_div_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .core_clk        (core_clk),
    .rst             (rst),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_op_i        (req_op_i),
    .req_a_i         (req_a_i),
    .req_b_i         (req_b_i),
    .rsp_valid_o     (rsp_valid_o),
    .rsp_ready_i     (rsp_ready_i),
    .rsp_result_o    (rsp_result_o),
    .rsp_err_o       (rsp_err_o),
    .div_enable_o    (div_enable_o),
    .div_operator_o  (div_operator_o),
    .div_operand_a_o (div_operand_a_o),
    .div_operand_b_o (div_operand_b_o),
    .div_ex_ready_o  (div_ex_ready_o),
    .div_ready_i     (div_ready_i),
    .div_result_i    (div_result_i)
  );

  initial begin
    core_clk = 1'b0;
    forever #5 core_clk = ~core_clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic is_div(input logic [6:0] op);
    return op == OP_DIVU || op == OP_DIV || op == OP_REMU || op == OP_REM;
  endfunction

  // RISC-V divide semantics in plain arithmetic, including /0 and signed overflow.
  function automatic logic [31:0] ref_div(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b);
    logic ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REMU: return (b == 0) ? a : a % b;
      OP_DIV:  return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
      OP_REM:  return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
      default: return 32'h0;
    endcase
  endfunction

  typedef struct {
    int          owner;
    logic [6:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    bit          no_div;
    bit          abort;
  } txn_t;

  txn_t exp_q[$];
  int   grant_log[$];
  bit   hang;
  int   en_cycles;

  // Divider stand-in: answers a fixed number of cycles into each enable window.
  int busy_cnt;
  initial begin
    busy_cnt     = 0;
    div_ready_i  = 1'b0;
    div_result_i = '0;
    forever begin
      @(posedge core_clk);
      #1;
      if (div_enable_o && !rst) begin
        busy_cnt++;
        if (!hang && busy_cnt == 2 + int'(div_operand_a_o[2:0])) begin
          div_ready_i  = 1'b1;
          div_result_i = ref_div(div_operator_o, div_operand_a_o, div_operand_b_o);
        end else begin
          div_ready_i  = 1'b0;
          div_result_i = '0;
        end
      end else begin
        busy_cnt     = 0;
        div_ready_i  = 1'b0;
        div_result_i = '0;
      end
    end
  end

  // Model-based compare; inputs change only just after posedge, so negedge sees what the next edge will.
  txn_t               cur, nt;
  logic               e_err;
  logic [31:0]        e_res;
  logic [NUM_REQ-1:0] acc;
  int                 last_gnt, cyc_since_acc, en_cnt, w, exp_w, cand;
  bit                 ready_prev, found;

  always @(negedge core_clk) begin
    if (rst) begin
      exp_q.delete();
      last_gnt      = NUM_REQ - 1;
      cyc_since_acc = 0;
      en_cnt        = 0;
      ready_prev    = 1'b0;
    end else begin
      if (div_enable_o) en_cycles++;
      check("req_ready_onehot", 32'($onehot0(req_ready_o)), 1);
      check("rsp_valid_onehot", 32'($onehot0(rsp_valid_o)), 1);
      check("ex_ready_tracks_en", div_ex_ready_o, div_enable_o);
      if (!div_enable_o)
        check("div_idle_operands", 32'(div_operator_o) | div_operand_a_o | div_operand_b_o, 0);

      if (exp_q.size() != 0) begin
        cur = exp_q[0];
        cyc_since_acc++;
        if (div_enable_o) en_cnt++;
        if (!cur.no_div && cur.abort) begin
          e_err = 1'b1; e_res = '0;
        end else if (!is_div(cur.op)) begin
          e_err = 1'b1; e_res = '0;
        end else begin
          e_err = 1'b0; e_res = ref_div(cur.op, cur.a, cur.b);
        end
        check("ready_while_busy", 32'(req_ready_o), 0);
        if (cur.no_div) begin
          check("div_en_bypass", div_enable_o, 0);
          if (cyc_since_acc == 1) check("bypass_rsp_t1", 32'(rsp_valid_o), 32'(1) << cur.owner);
        end else begin
          if (cyc_since_acc == 1) check("div_en_t1", div_enable_o, 1);
          if (ready_prev) check("rsp_at_d1", 32'(rsp_valid_o), 32'(1) << cur.owner);
          if (div_enable_o) begin
            check("div_operator", 32'(div_operator_o), 32'(cur.op));
            check("div_operand_a", div_operand_a_o, cur.a);
            check("div_operand_b", div_operand_b_o, cur.b);
            check("wd_bound", 32'(en_cnt <= TIMEOUT_CYC), 1);
          end
          if (cur.abort && rsp_valid_o != 0) check("abort_cycles", en_cnt, TIMEOUT_CYC);
        end
        if (rsp_valid_o != 0) begin
          check("rsp_owner", 32'(rsp_valid_o), 32'(1) << cur.owner);
          check("rsp_result", rsp_result_o, e_res);
          check("rsp_err", rsp_err_o, e_err);
          check("div_en_in_rsp", div_enable_o, 0);
        end
        ready_prev = div_enable_o && div_ready_i;
        if (rsp_valid_o[cur.owner] && rsp_ready_i[cur.owner]) begin
          void'(exp_q.pop_front());
          ready_prev = 1'b0;
        end
      end else begin
        check("idle_rsp_valid", 32'(rsp_valid_o), 0);
        check("idle_div_en", div_enable_o, 0);
      end

      acc = req_valid_i & req_ready_o;
      if (acc != 0) begin
        w = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) if (acc[i]) w = i;
        found = 1'b0;
        exp_w = -1;
        for (int off = 1; off <= NUM_REQ; off++) begin
          cand = (last_gnt + off) % NUM_REQ;
          if (!found && req_valid_i[cand]) begin
            exp_w = cand;
            found = 1'b1;
          end
        end
        check("rr_winner", w, exp_w);
        nt.owner  = w;
        nt.op     = req_op_i[w*7 +: 7];
        nt.a      = req_a_i[w*32 +: 32];
        nt.b      = req_b_i[w*32 +: 32];
        nt.no_div = !is_div(nt.op);
`ifdef ALU_DIV_ARB_FAST_ZERO_EN
        if (nt.b == 0) nt.no_div = 1'b1;
`endif
        nt.abort = hang && !nt.no_div;
        exp_q.push_back(nt);
        grant_log.push_back(w);
        last_gnt      = w;
        cyc_since_acc = 0;
        en_cnt        = 0;
        ready_prev    = 1'b0;
      end
    end
  end

  task automatic issue(input int r, input logic [6:0] op, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    req_op_i[r*7 +: 7]  = op;
    req_a_i[r*32 +: 32] = a;
    req_b_i[r*32 +: 32] = b;
    req_valid_i[r]      = 1'b1;
    do begin
      @(negedge core_clk);
      n++;
    end while (!req_ready_o[r] && n < 200);
    check("accept_wait", req_ready_o[r], 1);
    @(posedge core_clk);
    #1;
    req_valid_i[r] = 1'b0;
  endtask

  task automatic wait_rsp(input int r, output logic [31:0] res, output logic err);
    int n = 0;
    do begin
      @(negedge core_clk);
      n++;
    end while (!rsp_valid_o[r] && n < 200);
    check("rsp_wait", rsp_valid_o[r], 1);
    res = rsp_result_o;
    err = rsp_err_o;
    @(posedge core_clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || req_valid_i != 0) && n < 500) begin
      @(negedge core_clk);
      n++;
    end
    check("drain_wait", 32'(n < 500), 1);
    @(posedge core_clk);
    #1;
  endtask

  logic [31:0] res;
  logic        err;

  initial begin
    rst         = 1'b1;
    hang        = 1'b0;
    en_cycles   = 0;
    req_valid_i = '0;
    req_op_i    = '0;
    req_a_i     = '0;
    req_b_i     = '0;
    rsp_ready_i = '1;
    repeat (3) @(posedge core_clk);
    @(negedge core_clk);
    check("reset_rsp_valid", 32'(rsp_valid_o), 0);
    check("reset_div_en", div_enable_o, 0);
    check("reset_result", rsp_result_o, 0);
    @(posedge core_clk);
    #1;
    rst = 1'b0;
    @(posedge core_clk);
    #1;

    // DIVU 100/7; divider answers in its 6th enable cycle.
    en_cycles = 0;
    issue(0, OP_DIVU, 32'd100, 32'd7);
    wait_rsp(0, res, err);
    check("t1_result", res, 32'd14);
    check("t1_err", err, 0);
    check("t1_en_cycles", en_cycles, 6);

    issue(1, OP_REM, 32'hFFFF_FFF9, 32'd3);
    wait_rsp(1, res, err);
    check("t2_rem", res, 32'hFFFF_FFFF);
    check("t2_rem_err", err, 0);
    issue(1, OP_DIV, 32'hFFFF_FFF9, 32'd3);
    wait_rsp(1, res, err);
    check("t2_div", res, 32'hFFFF_FFFE);

    // Both requesters held valid for four operations.
    grant_log.delete();
    fork
      begin issue(0, OP_DIVU, 32'd50, 32'd5); issue(0, OP_DIVU, 32'd9, 32'd2); end
      begin issue(1, OP_DIVU, 32'd81, 32'd9); issue(1, OP_REMU, 32'd10, 32'd3); end
    join
    drain();
    check("t3_grants", grant_log.size(), 4);
    check("t3_order0", grant_log[0], 0);
    check("t3_order1", grant_log[1], 1);
    check("t3_order2", grant_log[2], 0);
    check("t3_order3", grant_log[3], 1);

    en_cycles = 0;
    issue(0, OP_DIVU, 32'd5, 32'd0);
    wait_rsp(0, res, err);
    check("t4_result", res, 32'hFFFF_FFFF);
    check("t4_err", err, 0);
`ifdef ALU_DIV_ARB_FAST_ZERO_EN
    check("t4_no_divider", en_cycles, 0);
`else
    check("t4_divider_path", en_cycles, 7);
`endif

    issue(0, OP_ADD, 32'd1, 32'd2);
    wait_rsp(0, res, err);
    check("illegal_err", err, 1);
    check("illegal_result", res, 0);

    issue(1, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_rsp(1, res, err);
    check("div_overflow", res, 32'h8000_0000);

    // Divider never answers: watchdog abort.
    hang      = 1'b1;
    en_cycles = 0;
    issue(1, OP_DIV, 32'd20, 32'd4);
    wait_rsp(1, res, err);
    check("t5_err", err, 1);
    check("t5_result", res, 0);
    check("t5_en_cycles", en_cycles, 40);
    hang = 1'b0;

    // Backpressure: result held, competing request not granted.
    rsp_ready_i[0] = 1'b0;
    issue(0, OP_DIVU, 32'd1000, 32'd10);
    wait_rsp(0, res, err);
    fork
      issue(1, OP_DIVU, 32'd64, 32'd8);
    join_none
    for (int i = 0; i < 10; i++) begin
      @(negedge core_clk);
      check("bp_valid", 32'(rsp_valid_o), 32'b01);
      check("bp_result", rsp_result_o, 32'd100);
      check("bp_no_grant", 32'(req_ready_o), 0);
    end
    @(posedge core_clk);
    #1;
    rsp_ready_i[0] = 1'b1;
    drain();

    // Reset while the divider is busy.
    hang = 1'b1;
    issue(0, OP_DIVU, 32'd7, 32'd1);
    repeat (5) @(posedge core_clk);
    #1;
    rst = 1'b1;
    @(negedge core_clk);
    check("rst_div_en", div_enable_o, 0);
    check("rst_div_operands", 32'(div_operator_o) | div_operand_a_o | div_operand_b_o, 0);
    check("rst_rsp", 32'(rsp_valid_o) | 32'(rsp_err_o) | rsp_result_o, 0);
    check("rst_req_ready", 32'(req_ready_o), 0);
    @(posedge core_clk);
    #1;
    hang = 1'b0;
    rst  = 1'b0;
    grant_log.delete();
    fork
      issue(1, OP_DIVU, 32'd9, 32'd3);
      issue(0, OP_REMU, 32'd9, 32'd4);
    join
    drain();
    check("post_rst_first", grant_log[0], 0);
    check("post_rst_second", grant_log[1], 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
